// File: rtl/xsleena_io_ctrl_gen.sv
// XSleena I/O window decoder: registered port reads, one-clk access strobes,
// flip/priority/bank control registers and debounced, queued coin-counter drivers.
//
// coin FSM state | meaning
// ST_IDLE        | counter released, waiting for a pending coin
// ST_ON          | counter driven for CNT_ON clk
// ST_OFF         | counter released for CNT_OFF clk before the next coin
module xsleena_io_ctrl_gen #(
  parameter int ABW        = 4,
  parameter int NRD        = 6,
  parameter int NCOIN      = 2,
  parameter int COIN_PORT  = 1,
  parameter int COIN_LSB   = 6,
  parameter int DEB_CYC    = 1024,
  parameter int CNT_ON     = 65536,
  parameter int CNT_OFF    = 65536,
  parameter int PEND_W     = 3,
  parameter int REG_P1P2_A = 13,
  parameter int REG_PRI_A  = 15
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic [ABW-1:0]       AB,
  input  logic                 IOn,
  input  logic                 RW,
  input  logic [7:0]           DB_in,
  output logic [7:0]           DB_out,
  input  logic [NRD*8-1:0]     RD_PORTS,
  input  logic [NCOIN-1:0]     COIN_INn,
  output logic [(2**ABW)-1:0]  RD_PULSE,
  output logic [(2**ABW)-1:0]  WR_PULSE,
  output logic [NCOIN-1:0]     COIN_CNT,
  output logic                 P1_P2n,
  output logic                 P1_P2,
  output logic [2:0]           PRI,
  output logic                 BSL
);

  localparam int NREG = 2**ABW;
  localparam int TMAX = (CNT_ON > CNT_OFF) ? CNT_ON : CNT_OFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} coin_st_t;

  logic             acc, acc_d, rd, first;
  logic [7:0]       rd_byte;
  logic [NCOIN-1:0] coin_deb;

  assign acc   = ~IOn;
  assign rd    = acc & RW;
  assign first = acc & ~acc_d;

  always_comb begin
    rd_byte = 8'hFF;
    for (int k = 0; k < NRD; k++) begin
      if (AB == ABW'(k)) begin
        rd_byte = RD_PORTS[8*k +: 8];
        if (k == COIN_PORT) rd_byte[COIN_LSB +: NCOIN] = coin_deb;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      acc_d    <= 1'b0;
      DB_out   <= 8'hFF;
      RD_PULSE <= '0;
      WR_PULSE <= '0;
      P1_P2n   <= 1'b0;
      PRI      <= 3'd0;
      BSL      <= 1'b0;
    end else begin
      acc_d    <= acc;
      DB_out   <= rd ? rd_byte : 8'hFF;
      RD_PULSE <= (first &  RW) ? (NREG'(1) << AB) : '0;
      WR_PULSE <= (first & ~RW) ? (NREG'(1) << AB) : '0;
      if (first && !RW) begin
        if (AB == ABW'(REG_P1P2_A)) P1_P2n <= DB_in[0];
        if (AB == ABW'(REG_PRI_A)) {BSL, PRI} <= DB_in[3:0];
      end
    end
  end

  assign P1_P2 = ~P1_P2n;

  for (genvar i = 0; i < NCOIN; i++) begin : g_coin
    logic              s1, s2, deb, press, take;
    logic [DW-1:0]     deb_cnt;
    logic [PEND_W-1:0] pend;
    logic [TW-1:0]     tmr, tmr_nxt;
    coin_st_t          st, st_nxt;

    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        s1      <= 1'b1;
        s2      <= 1'b1;
        deb     <= 1'b1;
        deb_cnt <= '0;
      end else begin
        s1 <= COIN_INn[i];
        s2 <= s1;
        if (s2 == deb) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYC-1)) begin
          deb     <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end
    end

    // a press is the accepted 1->0 transition of the debounced level
    assign press = deb & ~s2 & (deb_cnt == DW'(DEB_CYC-1));

    always_comb begin
      st_nxt  = st;
      tmr_nxt = tmr;
      take    = 1'b0;
      case (st)
        ST_IDLE: if (pend != '0) begin
          st_nxt  = ST_ON;
          tmr_nxt = TW'(CNT_ON-1);
          take    = 1'b1;
        end
        ST_ON: if (tmr == '0) begin
          st_nxt  = ST_OFF;
          tmr_nxt = TW'(CNT_OFF-1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
        ST_OFF: if (tmr == '0) st_nxt = ST_IDLE;
                else tmr_nxt = tmr - TW'(1);
        default: st_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        st   <= ST_IDLE;
        tmr  <= '0;
        pend <= '0;
      end else begin
        st  <= st_nxt;
        tmr <= tmr_nxt;
        // simultaneous press and take cancel; saturated presses are dropped
        if (press && !take && pend != '1) pend <= pend + PEND_W'(1);
        else if (take && !press)          pend <= pend - PEND_W'(1);
      end
    end

    assign COIN_CNT[i] = (st == ST_ON);
    assign coin_deb[i] = deb;
  end

endmodule

// File: tb/tb_xsleena_io_ctrl_gen.sv
// Directed bench for xsleena_io_ctrl_gen: a short-timer instance for decode and
// coin timing, and a long-timer instance for pending saturation and reset abort.
module tb_xsleena_io_ctrl_gen;

  logic        clk = 1'b0;
  logic        RSTn;
  logic [3:0]  AB;
  logic        IOn, RW;
  logic [7:0]  DB_in;
  logic [47:0] RD_PORTS;
  logic [1:0]  COIN_INn, coin_sat;

  logic [7:0]  DB_out, s_db_out;
  logic [15:0] RD_PULSE, WR_PULSE, s_rd_pulse, s_wr_pulse;
  logic [1:0]  COIN_CNT, s_coin_cnt;
  logic        P1_P2n, P1_P2, s_p1_p2n, s_p1_p2, BSL, s_bsl;
  logic [2:0]  PRI, s_pri;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xsleena_io_ctrl_gen #(.DEB_CYC(8), .CNT_ON(4), .CNT_OFF(4)) dut (
    .clk(clk), .RSTn(RSTn), .AB(AB), .IOn(IOn), .RW(RW), .DB_in(DB_in),
    .DB_out(DB_out), .RD_PORTS(RD_PORTS), .COIN_INn(COIN_INn),
    .RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE), .COIN_CNT(COIN_CNT),
    .P1_P2n(P1_P2n), .P1_P2(P1_P2), .PRI(PRI), .BSL(BSL));

  xsleena_io_ctrl_gen #(.DEB_CYC(8), .CNT_ON(256), .CNT_OFF(256)) u_sat (
    .clk(clk), .RSTn(RSTn), .AB(AB), .IOn(IOn), .RW(RW), .DB_in(DB_in),
    .DB_out(s_db_out), .RD_PORTS(RD_PORTS), .COIN_INn(coin_sat),
    .RD_PULSE(s_rd_pulse), .WR_PULSE(s_wr_pulse), .COIN_CNT(s_coin_cnt),
    .P1_P2n(s_p1_p2n), .P1_P2(s_p1_p2), .PRI(s_pri), .BSL(s_bsl));

  // pulse monitor for coin channel 0 of both instances and channel 1 of dut
  int rise0 = 0, rise1 = 0, rise_s = 0, bad_on = 0, bad_off = 0;
  int hrun = 0, lrun = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, prev_s = 1'b0, ever0 = 1'b0;

  always @(negedge clk) begin
    if (RSTn) begin
      if (COIN_CNT[0] && !prev0) rise0 <= rise0 + 1;
      if (COIN_CNT[1] && !prev1) rise1 <= rise1 + 1;
      if (s_coin_cnt[0] && !prev_s) rise_s <= rise_s + 1;
      if (!COIN_CNT[0] && prev0 && hrun != 4) bad_on <= bad_on + 1;
      if (COIN_CNT[0] && !prev0 && ever0 && lrun < 4) bad_off <= bad_off + 1;
      hrun  <= COIN_CNT[0] ? hrun + 1 : 0;
      lrun  <= COIN_CNT[0] ? 0 : lrun + 1;
      ever0 <= ever0 | COIN_CNT[0];
    end
    prev0  <= COIN_CNT[0];
    prev1  <= COIN_CNT[1];
    prev_s <= s_coin_cnt[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_main(input int lo, input int hi);
    COIN_INn[0] = 1'b0;
    tick(lo);
    COIN_INn[0] = 1'b1;
    tick(hi);
  endtask

  task automatic press_sat(input int lo, input int hi);
    coin_sat[0] = 1'b0;
    tick(lo);
    coin_sat[0] = 1'b1;
    tick(hi);
  endtask

  task automatic access(input logic [3:0] a, input logic r, input logic [7:0] d);
    AB = a; RW = r; DB_in = d; IOn = 1'b0;
    tick();
  endtask

  task automatic release_bus();
    IOn = 1'b1; RW = 1'b1;
    tick();
  endtask

  int n, bad, r0, r1, rs, bon, boff;

  initial begin
    RSTn = 1'b0; AB = '0; IOn = 1'b1; RW = 1'b1; DB_in = '0;
    COIN_INn = 2'b11; coin_sat = 2'b11;
    RD_PORTS = {8'hA5, 8'h44, 8'h33, 8'h5A, 8'h0F, 8'h11};
    tick(3);
    check("rst_db_out", DB_out, 8'hFF);
    check("rst_pulses", {RD_PULSE, WR_PULSE}, 0);
    check("rst_coin_cnt", COIN_CNT, 0);
    check("rst_flip", {P1_P2n, P1_P2}, 2'b01);
    check("rst_pri_bsl", {BSL, PRI}, 4'h0);

    RSTn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (DB_out != 8'hFF || RD_PULSE != 0 || WR_PULSE != 0 || COIN_CNT != 0 ||
          P1_P2 != 1'b1 || PRI != 0 || BSL != 1'b0) bad++;
    end
    check("idle_hold", bad, 0);

    // read port 2 held 4 clk
    access(4'd2, 1'b1, 8'h00);
    check("rd2_first_data", DB_out, 8'h5A);
    check("rd2_first_pulse", RD_PULSE, 16'h0004);
    n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd2_held_data", DB_out, 8'h5A);
      if (RD_PULSE[2]) n++;
    end
    check("rd2_pulse_count", n, 1);
    release_bus();
    check("rd_release_data", DB_out, 8'hFF);

    access(4'd9, 1'b1, 8'h00);
    check("rd9_data", DB_out, 8'hFF);
    check("rd9_pulse", RD_PULSE, 16'h0200);
    release_bus();
    access(4'd5, 1'b1, 8'h00);
    check("rd5_last_port", DB_out, 8'hA5);
    release_bus();
    access(4'd6, 1'b1, 8'h00);
    check("rd6_past_ports", DB_out, 8'hFF);
    release_bus();
    access(4'd1, 1'b1, 8'h00);
    check("rd1_coin_idle", DB_out, 8'hCF);
    release_bus();

    // write PRI/BSL, data changes after the first cycle must be ignored
    access(4'd15, 1'b0, 8'h0D);
    check("wr15_pulse", WR_PULSE, 16'h8000);
    check("wr15_db_out", DB_out, 8'hFF);
    n = 1;
    DB_in = 8'h02;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (WR_PULSE[15]) n++;
    end
    check("wr15_pulse_count", n, 1);
    check("wr15_pri", PRI, 3'd5);
    check("wr15_bsl", BSL, 1'b1);
    release_bus();
    access(4'd13, 1'b0, 8'h01);
    check("wr13_flip", {P1_P2n, P1_P2}, 2'b10);
    check("wr13_pri_kept", {BSL, PRI}, 4'hD);
    release_bus();
    access(4'd15, 1'b1, 8'h00);
    check("rd15_no_write", {BSL, PRI, P1_P2n}, 5'b11011);
    release_bus();

    // glitch shorter than the debounce window
    r0 = rise0;
    press_main(5, 40);
    check("glitch_no_pulse", rise0 - r0, 0);

    // held press: one pulse, coin bit reads pressed while held
    r0 = rise0; r1 = rise1; bon = bad_on;
    COIN_INn[0] = 1'b0;
    tick(20);
    access(4'd1, 1'b1, 8'h00);
    check("rd1_coin_pressed", DB_out, 8'h8F);
    release_bus();
    COIN_INn[0] = 1'b1;
    tick(30);
    check("held_one_pulse", rise0 - r0, 1);
    check("held_pulse_len", bad_on - bon, 0);
    check("ch1_untouched", rise1 - r1, 0);
    access(4'd1, 1'b1, 8'h00);
    check("rd1_coin_released", DB_out, 8'hCF);
    release_bus();

    // three rapid presses
    r0 = rise0; bon = bad_on; boff = bad_off;
    for (int i = 0; i < 3; i++) press_main(12, 12);
    tick(40);
    check("rapid_pulses", rise0 - r0, 3);
    check("rapid_on_len", bad_on - bon, 0);
    check("rapid_off_len", bad_off - boff, 0);

    // ten presses during one long pulse: 1 issued + 7 pending
    rs = rise_s;
    for (int i = 0; i < 10; i++) press_sat(10, 10);
    tick(4300);
    check("sat_pulses", rise_s - rs, 8);
    check("sat_idle_after", s_coin_cnt, 2'b00);

    // reset while ON with two coins pending
    rs = rise_s;
    for (int i = 0; i < 3; i++) press_sat(10, 10);
    check("abort_pre_on", s_coin_cnt[0], 1'b1);
    RSTn = 1'b0;
    #1;
    check("abort_cnt_now", s_coin_cnt, 2'b00);
    tick(2);
    check("abort_regs", {BSL, PRI, P1_P2n, P1_P2}, 6'b000001);
    check("abort_db_out", s_db_out, 8'hFF);
    RSTn = 1'b1;
    rs = rise_s;
    tick(700);
    check("abort_no_resume", rise_s - rs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
